i2s_frame_sequencer: RTL and testbench

Master-mode I2S frame sequencer between the APB register block's FIFO handshake and the serial pins. Generates SCK/WS from `pclk` via a programmable divider. Fetches one Tx FIFO word per channel into a shift register and serialises it MSB-first on `sd_out`. Deserialises `sd_in` into words pushed to the Rx FIFO, with sticky underrun/overrun reporting back to the control/status register.

---
 rtl/i2s_frame_sequencer_if.sv | 23 ++
 rtl/i2s_frame_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_sequencer_if.sv
// rtl/i2s_frame_sequencer_if.sv - Tx/Rx FIFO handshake bundle between the I2S frame sequencer and the register block
interface i2s_frame_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              Tx_empty;
  logic [DATA_W-1:0] Tx_data;
  logic              Tx_ren;
  logic              Rx_full;
  logic              Rx_wen;
  logic [DATA_W-1:0] Rx_data;

  // Sequencer side: pops Tx words, pushes Rx words
  modport master (
    input  Tx_empty, Tx_data, Rx_full,
    output Tx_ren, Rx_wen, Rx_data
  );

  // FIFO side
  modport slave (
    output Tx_empty, Tx_data, Rx_full,
    input  Tx_ren, Rx_wen, Rx_data
  );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// rtl/i2s_frame_sequencer.sv - master-mode I2S frame sequencer; optional I2S_LOOPBACK_EN samples sd_out instead of sd_in
module i2s_frame_sequencer #(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  enable,
  input  logic [1:0]            word_len,
  input  logic [DIV_W-1:0]      clk_div,
  input  logic                  clr_flags,
  i2s_frame_sequencer_if.master fifo,
  input  logic                  sd_in,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd_out,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, STOP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_lat, div_eff;
  logic [1:0]        wl_lat;
  logic [5:0]        bitcnt, bitcnt_inc, bitcnt_ws, n_bits;
  logic [4:0]        off_now, off_nxt;
  logic [DATA_W-1:0] tx_sr, tx_hold, rx_sr, rx_next, fetch_word;
  logic              run_first, fetch_d, ren_d, push_pend;
  logic              active, tick, rise, fall, frame_end;
  logic              prefetch, fetch, underrun_set, overrun_set;
  logic              sample, new_msb;

`ifdef I2S_LOOPBACK_EN
  logic unused_sd_in;
  assign unused_sd_in = sd_in;
  assign sample       = sd_out;
`else
  assign sample       = sd_in;
`endif

  // A divider of 0 would make SCK as fast as pclk and break the Tx load spacing
  assign div_eff    = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign active     = (state == RUN) || (state == STOP);
  assign tick       = active && (div_cnt == div_lat);
  assign rise       = tick && !sck;
  assign fall       = tick && sck;
  assign bitcnt_inc = bitcnt + 6'd1;
  assign bitcnt_ws  = bitcnt + 6'd2;
  assign frame_end  = fall && (bitcnt == 6'd63);
  assign off_now    = bitcnt[4:0];
  assign off_nxt    = bitcnt_inc[4:0];
  assign n_bits     = {1'b0, wl_lat, 3'b000} + 6'd8;
  assign fetch_word = ren_d ? fifo.Tx_data : '0;
  // Channel boundaries reload from the holding register instead of shifting
  assign new_msb    = (off_nxt == 5'd0) ? tx_hold[DATA_W-1] : tx_sr[DATA_W-2];
  // Right channel is always fetched; the next frame's left word only while still running
  assign prefetch   = rise && ((bitcnt == 6'd31) ||
                               ((bitcnt == 6'd63) && (state == RUN) && enable));

  // Received word under construction: cleared at channel offset 0, filled MSB first
  always_comb begin
    rx_next = (off_now == 5'd0) ? '0 : rx_sr;
    rx_next[5'd31 - off_now] = sample;
  end

  // State register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; STOP lets the current frame run to its last SCK
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = PRIME;
      PRIME:   state_nxt = RUN;
      RUN:     if (!enable) state_nxt = STOP;
      STOP:    if (frame_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: FIFO strobes and error-flag set conditions
  always_comb begin
    busy         = (state != IDLE);
    fetch        = (state == PRIME) || prefetch;
    fifo.Tx_ren  = fetch && !fifo.Tx_empty;
    fifo.Rx_wen  = push_pend && !fifo.Rx_full;
    underrun_set = fetch && fifo.Tx_empty;
    overrun_set  = push_pend && fifo.Rx_full;
  end

  // Tx fetch pipeline, holding register and per-frame config latch
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      run_first <= 1'b0;
      fetch_d   <= 1'b0;
      ren_d     <= 1'b0;
      tx_hold   <= '0;
      wl_lat    <= 2'd0;
      div_lat   <= '0;
    end else begin
      run_first <= (state == PRIME);
      fetch_d   <= fetch;
      ren_d     <= fifo.Tx_ren;
      if (fetch_d) tx_hold <= fetch_word;
      if ((state == PRIME) || (frame_end && (state == RUN))) begin
        wl_lat  <= word_len;
        div_lat <= div_eff;
      end
    end
  end

  // SCK divider: toggles sck every div_lat+1 pclk cycles while a frame is active
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (!active) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Transmit side: bit counter, word select and MSB-first shift register
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      bitcnt <= 6'd0;
      ws     <= 1'b0;
      sd_out <= 1'b0;
      tx_sr  <= '0;
    end else if (run_first) begin
      bitcnt <= 6'd0;
      ws     <= 1'b0;
      tx_sr  <= fetch_word;
      sd_out <= fetch_word[DATA_W-1];
    end else if (!active) begin
      bitcnt <= 6'd0;
      ws     <= 1'b0;
      sd_out <= 1'b0;
    end else if (fall) begin
      bitcnt <= bitcnt_inc;
      if (frame_end && (state == STOP)) begin
        ws     <= 1'b0;
        sd_out <= 1'b0;
      end else begin
        ws     <= bitcnt_ws[5];
        tx_sr  <= (off_nxt == 5'd0) ? tx_hold : (tx_sr << 1);
        sd_out <= ({1'b0, off_nxt} < n_bits) ? new_msb : 1'b0;
      end
    end
  end

  // Receive side: sample on SCK rise, push the word one pclk after its last bit
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      rx_sr        <= '0;
      push_pend    <= 1'b0;
      fifo.Rx_data <= '0;
    end else begin
      push_pend <= 1'b0;
      if (rise && ({1'b0, off_now} < n_bits)) begin
        rx_sr <= rx_next;
        if ({1'b0, off_now} == (n_bits - 6'd1)) begin
          push_pend    <= 1'b1;
          fifo.Rx_data <= rx_next;
        end
      end
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (underrun_set)   underrun <= 1'b1;
      else if (clr_flags) underrun <= 1'b0;
      if (overrun_set)    overrun  <= 1'b1;
      else if (clr_flags) overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// tb/tb_i2s_frame_sequencer.sv - directed bench for i2s_frame_sequencer with external sd_out->sd_in loopback
module tb_i2s_frame_sequencer;

  logic       pclk = 1'b0;
  logic       preset, enable, clr_flags, rx_full;
  logic [1:0] word_len;
  logic [7:0] clk_div;
  logic       sd_in, sck, ws, sd_out, busy, underrun, overrun;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  i2s_frame_sequencer_if fif ();

  i2s_frame_sequencer dut (
    .pclk      (pclk),
    .preset    (preset),
    .enable    (enable),
    .word_len  (word_len),
    .clk_div   (clk_div),
    .clr_flags (clr_flags),
    .fifo      (fif),
    .sd_in     (sd_in),
    .sck       (sck),
    .ws        (ws),
    .sd_out    (sd_out),
    .busy      (busy),
    .underrun  (underrun),
    .overrun   (overrun)
  );

  assign sd_in = sd_out;

  // Tx FIFO model: data valid the pclk after the pop
  logic [31:0] tx_mem [0:15];
  int tx_wr = 0;
  int tx_rd = 0;
  assign fif.Tx_empty = (tx_rd == tx_wr);
  assign fif.Rx_full  = rx_full;

  always @(posedge pclk) begin
    if (fif.Tx_ren) begin
      fif.Tx_data <= tx_mem[tx_rd[3:0]];
      tx_rd       <= tx_rd + 1;
    end
  end

  // Strobe monitors
  int          tx_ren_n = 0;
  int          rx_wen_n = 0;
  int          ren_b2b  = 0;
  logic        ren_prev = 1'b0;
  logic [31:0] rx_log [0:63];

  always @(posedge pclk) begin
    ren_prev <= fif.Tx_ren;
    if (fif.Tx_ren) tx_ren_n <= tx_ren_n + 1;
    if (fif.Tx_ren && ren_prev) ren_b2b <= ren_b2b + 1;
    if (fif.Rx_wen) begin
      rx_log[rx_wen_n[5:0]] <= fif.Rx_data;
      rx_wen_n <= rx_wen_n + 1;
    end
  end

  // Pin monitor: sd_out and ws captured at every SCK rise
  int   sck_n = 0;
  logic sdo_mon [0:2047];
  logic ws_mon  [0:2047];

  always @(posedge sck) begin
    sdo_mon[sck_n[10:0]] <= sd_out;
    ws_mon[sck_n[10:0]]  <= ws;
    sck_n <= sck_n + 1;
  end

  task automatic push_tx(input logic [31:0] w);
    tx_mem[tx_wr[3:0]] = w;
    tx_wr = tx_wr + 1;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic wait_rises(input int target, output bit ok);
    int n = 0;
    while (sck_n < target && n < 3000) begin
      @(negedge pclk);
      n++;
    end
    ok = (sck_n >= target);
  endtask

  task automatic play_frame(input logic [1:0] wl, input logic [7:0] cd, output bit ok);
    word_len = wl;
    clk_div  = cd;
    enable   = 1'b1;
    repeat (3) @(negedge pclk);
    enable   = 1'b0;
    wait_idle(ok);
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    @(negedge pclk);
    clr_flags = 1'b0;
    @(negedge pclk);
  endtask

  function automatic logic [63:0] frame_sdo(input int s);
    logic [63:0] v;
    for (int j = 0; j < 64; j++) v[63-j] = sdo_mon[(s + j) % 2048];
    return v;
  endfunction

  function automatic logic [63:0] frame_ws(input int s);
    logic [63:0] v;
    for (int j = 0; j < 64; j++) v[j] = ws_mon[(s + j) % 2048];
    return v;
  endfunction

  task automatic test_reset();
    logic [7:0] pins;
    preset = 1'b0; enable = 1'b0; clr_flags = 1'b0; rx_full = 1'b0;
    word_len = 2'b11; clk_div = 8'd1;
    repeat (3) @(negedge pclk);
    pins = {sck, ws, sd_out, busy, fif.Tx_ren, fif.Rx_wen, underrun, overrun};
    total++;
    if (pins !== 8'h00) begin
      bad++; $display("FAIL reset_pins: got %b want 00000000", pins);
    end
    total++;
    if (fif.Rx_data !== 32'h0) begin
      bad++; $display("FAIL reset_rx_data: got %h want 00000000", fif.Rx_data);
    end
    preset = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_basic_frame();
    int s, t0, r0;
    bit ok;
    logic [2:0] pins;
    @(negedge pclk);
    s = sck_n; t0 = tx_ren_n; r0 = rx_wen_n;
    push_tx(32'hA5A5_0001);
    push_tx(32'h5A5A_0002);
    play_frame(2'b11, 8'd1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (tx_ren_n - t0 !== 2) begin bad++; $display("FAIL basic_tx_ren: got %0d want 2", tx_ren_n - t0); end
    total++;
    if (rx_wen_n - r0 !== 2) begin bad++; $display("FAIL basic_rx_wen: got %0d want 2", rx_wen_n - r0); end
    total++;
    if (rx_log[r0[5:0]] !== 32'hA5A5_0001) begin
      bad++; $display("FAIL basic_rx0: got %h want a5a50001", rx_log[r0[5:0]]);
    end
    total++;
    if (rx_log[r0[5:0]+6'd1] !== 32'h5A5A_0002) begin
      bad++; $display("FAIL basic_rx1: got %h want 5a5a0002", rx_log[r0[5:0]+6'd1]);
    end
    total++;
    if (sck_n - s !== 64) begin bad++; $display("FAIL basic_sck_count: got %0d want 64", sck_n - s); end
    total++;
    if (frame_ws(s) !== 64'h7FFF_FFFF_8000_0000) begin
      bad++; $display("FAIL basic_ws: got %h want 7fffffff80000000", frame_ws(s));
    end
    total++;
    if (frame_sdo(s) !== 64'hA5A5_0001_5A5A_0002) begin
      bad++; $display("FAIL basic_sd_out: got %h want a5a500015a5a0002", frame_sdo(s));
    end
    pins = {sck, ws, sd_out};
    total++;
    if (pins !== 3'b000) begin bad++; $display("FAIL basic_idle_pins: got %b want 000", pins); end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL basic_no_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_16bit();
    int s, r0;
    bit ok;
    @(negedge pclk);
    s = sck_n; r0 = rx_wen_n;
    push_tx(32'h1234_FFFF);
    push_tx(32'h8765_FFFF);
    play_frame(2'b01, 8'd1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL w16_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (frame_sdo(s) !== 64'h1234_0000_8765_0000) begin
      bad++; $display("FAIL w16_sd_out: got %h want 1234000087650000", frame_sdo(s));
    end
    total++;
    if (rx_log[r0[5:0]] !== 32'h1234_0000) begin
      bad++; $display("FAIL w16_rx0: got %h want 12340000", rx_log[r0[5:0]]);
    end
    total++;
    if (rx_log[r0[5:0]+6'd1] !== 32'h8765_0000) begin
      bad++; $display("FAIL w16_rx1: got %h want 87650000", rx_log[r0[5:0]+6'd1]);
    end
  endtask

  task automatic test_timing();
    int n, c, base, t0;
    bit ok;
    @(negedge pclk);
    t0 = tx_ren_n;
    push_tx(32'h0F0F_0F0F);
    push_tx(32'hF0F0_F0F0);
    word_len = 2'b11;
    clk_div  = 8'd0;
    enable   = 1'b1;
    @(negedge pclk);
    total++;
    if ({busy, fif.Tx_ren} !== 2'b11) begin
      bad++; $display("FAIL prime_ren: got busy/ren %b want 11", {busy, fif.Tx_ren});
    end
    n = 1;
    while (sck !== 1'b1 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    total++;
    if (n !== 4) begin bad++; $display("FAIL first_rise: got cycle %0d want 4", n); end
    base = sck_n;
    c = 0;
    while (sck_n == base && c < 50) begin
      @(negedge pclk);
      c++;
    end
    total++;
    if (c !== 4) begin bad++; $display("FAIL sck_period: got %0d want 4", c); end
    enable = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL timing_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (tx_ren_n - t0 !== 2) begin bad++; $display("FAIL timing_tx_ren: got %0d want 2", tx_ren_n - t0); end
  endtask

  task automatic test_underrun();
    int s, t0, r0;
    bit ok;
    @(negedge pclk);
    s = sck_n; t0 = tx_ren_n; r0 = rx_wen_n;
    word_len = 2'b11;
    clk_div  = 8'd1;
    enable   = 1'b1;
    @(negedge pclk);
    clr_flags = 1'b1;
    @(negedge pclk);
    clr_flags = 1'b0;
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set_wins: got %b want 1", underrun); end
    @(negedge pclk);
    enable = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL underrun_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (frame_sdo(s) !== 64'h0) begin
      bad++; $display("FAIL underrun_sd_out: got %h want 0000000000000000", frame_sdo(s));
    end
    total++;
    if (tx_ren_n - t0 !== 0) begin bad++; $display("FAIL underrun_tx_ren: got %0d want 0", tx_ren_n - t0); end
    total++;
    if ({rx_log[r0[5:0]], rx_log[r0[5:0]+6'd1]} !== 64'h0) begin
      bad++; $display("FAIL underrun_rx: got %h %h want zeros", rx_log[r0[5:0]], rx_log[r0[5:0]+6'd1]);
    end
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
    pulse_clr();
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear: got %b want 0", underrun); end
  endtask

  task automatic test_overrun();
    int s, r0;
    bit ok;
    @(negedge pclk);
    s = sck_n; r0 = rx_wen_n;
    rx_full = 1'b1;
    push_tx(32'hCAFE_0001);
    push_tx(32'hCAFE_0002);
    word_len = 2'b11;
    clk_div  = 8'd1;
    enable   = 1'b1;
    repeat (3) @(negedge pclk);
    enable = 1'b0;
    wait_rises(s + 31, ok);
    total++;
    if (!ok || overrun !== 1'b0) begin bad++; $display("FAIL overrun_before: got %b want 0", overrun); end
    wait_rises(s + 32, ok);
    repeat (2) @(negedge pclk);
    total++;
    if (!ok || overrun !== 1'b1) begin bad++; $display("FAIL overrun_first_ch: got %b want 1", overrun); end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL overrun_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (rx_wen_n - r0 !== 0) begin bad++; $display("FAIL overrun_rx_wen: got %0d want 0", rx_wen_n - r0); end
    rx_full = 1'b0;
    pulse_clr();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
  endtask

  task automatic test_stop();
    int s, t0, r0;
    bit ok;
    @(negedge pclk);
    s = sck_n; t0 = tx_ren_n; r0 = rx_wen_n;
    push_tx(32'h1111_1111);
    push_tx(32'h2222_2222);
    push_tx(32'h3333_3333);
    word_len = 2'b11;
    clk_div  = 8'd1;
    enable   = 1'b1;
    wait_rises(s + 41, ok);
    enable = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL stop_reach_40: got rises %0d want 41", sck_n - s); end
    wait_idle(ok);
    total++;
    if (!ok || sck !== 1'b0) begin bad++; $display("FAIL stop_idle: got busy=%b sck=%b want 0 0", busy, sck); end
    total++;
    if (sck_n - s !== 64) begin bad++; $display("FAIL stop_frame_len: got %0d want 64", sck_n - s); end
    total++;
    if (tx_ren_n - t0 !== 2) begin bad++; $display("FAIL stop_no_prefetch: got %0d want 2", tx_ren_n - t0); end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL stop_underrun: got %b want 0", underrun); end
    total++;
    if (rx_log[r0[5:0]+6'd1] !== 32'h2222_2222) begin
      bad++; $display("FAIL stop_rx1: got %h want 22222222", rx_log[r0[5:0]+6'd1]);
    end
  endtask

  task automatic test_reset_midframe();
    int s, t_rst;
    bit ok;
    logic [7:0] pins;
    @(negedge pclk);
    s = sck_n;
    push_tx(32'h4444_4444);
    word_len = 2'b11;
    clk_div  = 8'd1;
    enable   = 1'b1;
    wait_rises(s + 21, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_reach_20: got rises %0d want 21", sck_n - s); end
    preset = 1'b0;
    t_rst  = tx_ren_n;
    #1;
    pins = {sck, ws, sd_out, busy, fif.Tx_ren, fif.Rx_wen, underrun, overrun};
    total++;
    if (pins !== 8'h00) begin bad++; $display("FAIL rst_mid_pins: got %b want 00000000", pins); end
    total++;
    if (fif.Rx_data !== 32'h0) begin bad++; $display("FAIL rst_mid_rx_data: got %h want 00000000", fif.Rx_data); end
    enable = 1'b0;
    @(negedge pclk);
    preset = 1'b1;
    repeat (6) @(negedge pclk);
    total++;
    if ({busy, sck, ws} !== 3'b000 || tx_ren_n !== t_rst) begin
      bad++; $display("FAIL rst_stays_idle: got busy/sck/ws %b pops %0d want 000 0", {busy, sck, ws}, tx_ren_n - t_rst);
    end
    enable = 1'b1;
    @(negedge pclk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_restart: got busy=%b want 1", busy); end
    enable = 1'b0;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_final_idle: timeout, busy=%b want 0", busy); end
    total++;
    if (ren_b2b !== 0) begin bad++; $display("FAIL tx_ren_back_to_back: got %0d want 0", ren_b2b); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_16bit();
    test_timing();
    test_underrun();
    test_overrun();
    test_stop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
